mips_regfile_np: RTL and testbench

Parametrised general-purpose register file for the MIPS datapath. It is the successor to the fixed 32×32 two-read/one-write file, and adds:
- configurable data width and depth;
- per-byte write enables;
- a hardware clear engine that zeroes the array one entry per cycle after reset or on request, reporting `Busy` while it runs;
- optional write-to-read forwarding.

It sits between instruction decode (read addresses) and the write-back stage (write port).

---
 rtl/mips_regfile_np.sv | 134 +++++++++++++
 tb/tb_mips_regfile_np.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_np.sv
// Parametrised MIPS register file: byte-enabled write port, two combinational read ports and a
// hardware clear sweep. Define REGFILE_BYPASS_EN to forward an accepted write onto the read ports.
module mips_regfile_np #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [ADDR_W-1:0]   R_Addr_A,
  input  logic [ADDR_W-1:0]   R_Addr_B,
  output logic [DATA_W-1:0]   R_Data_A,
  output logic [DATA_W-1:0]   R_Data_B,
  input  logic [ADDR_W-1:0]   W_Addr,
  input  logic [DATA_W-1:0]   W_Data,
  input  logic [DATA_W/8-1:0] W_Byte_En,
  input  logic                Write_Reg,
  input  logic                Clr_Req,
  output logic                Busy,
  output logic                Write_Reject
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam int unsigned NBytes = DATA_W / 8;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                busy_q;
  logic                reject_q;
  logic [DATA_W-1:0]   mem_q [Depth];

  logic                wr_accept;
  logic                wr_refuse;
  logic [DATA_W-1:0]   wr_merged;
  logic                arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_data;

  // Address-0 writes are discarded silently, so they are neither accepted nor refused.
  always_comb begin
    wr_accept = Write_Reg && (state_q == StIdle) && !Clr_Req && (W_Addr != '0);
    wr_refuse = Write_Reg && (W_Addr != '0) && ((state_q == StSweep) || Clr_Req);
  end

  always_comb begin
    wr_merged = mem_q[W_Addr];
    for (int k = 0; k < NBytes; k++) begin
      if (W_Byte_En[k]) begin
        wr_merged[8*k +: 8] = W_Data[8*k +: 8];
      end
    end
  end

  always_comb begin
    arr_we   = 1'b0;
    arr_addr = W_Addr;
    arr_data = wr_merged;
    if (Reset_n) begin
      if (state_q == StSweep) begin
        arr_we   = 1'b1;
        arr_addr = ptr_q;
        arr_data = '0;
      end else if (wr_accept) begin
        arr_we = 1'b1;
      end
    end
  end

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge Clk) begin
    if (arr_we) begin
      mem_q[arr_addr] <= arr_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StSweep;
      ptr_q    <= ADDR_W'(1);
      busy_q   <= 1'b1;
      reject_q <= 1'b0;
    end else begin
      reject_q <= wr_refuse;
      unique case (state_q)
        StIdle: begin
          if (Clr_Req) begin
            state_q <= StSweep;
            ptr_q   <= ADDR_W'(1);
            busy_q  <= 1'b1;
          end
        end
        StSweep: begin
          if (ptr_q == {ADDR_W{1'b1}}) begin
            state_q <= StIdle;
            ptr_q   <= ADDR_W'(1);
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= StSweep;
          ptr_q   <= ADDR_W'(1);
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
    logic [DATA_W-1:0] val;
    if (busy_q || (raddr == '0)) begin
      val = '0;
    end else begin
      val = mem_q[raddr];
`ifdef REGFILE_BYPASS_EN
      if (wr_accept && (W_Addr == raddr)) begin
        val = wr_merged;
      end
`endif
    end
    return val;
  endfunction

  always_comb begin
    R_Data_A = read_port(R_Addr_A);
    R_Data_B = read_port(R_Addr_B);
  end

  assign Busy         = busy_q;
  assign Write_Reject = reject_q;

endmodule

// File: tb/tb_mips_regfile_np.sv
// Directed self-checking bench for mips_regfile_np (DATA_W=32, ADDR_W=5).
module tb_mips_regfile_np;

  logic        Clk;
  logic        Reset_n;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [31:0] R_Data_A;
  logic [31:0] R_Data_B;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [3:0]  W_Byte_En;
  logic        Write_Reg;
  logic        Clr_Req;
  logic        Busy;
  logic        Write_Reject;

  int checks;
  int failures;

  mips_regfile_np #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .R_Addr_A     (R_Addr_A),
    .R_Addr_B     (R_Addr_B),
    .R_Data_A     (R_Data_A),
    .R_Data_B     (R_Data_B),
    .W_Addr       (W_Addr),
    .W_Data       (W_Data),
    .W_Byte_En    (W_Byte_En),
    .Write_Reg    (Write_Reg),
    .Clr_Req      (Clr_Req),
    .Busy         (Busy),
    .Write_Reject (Write_Reject)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] fwd_exp;
    checks    = 0;
    failures  = 0;
    Reset_n   = 1'b0;
    R_Addr_A  = 5'd3;
    R_Addr_B  = 5'd0;
    W_Addr    = 5'd3;
    W_Data    = 32'h1234_5678;
    W_Byte_En = 4'hF;
    Write_Reg = 1'b1;
    Clr_Req   = 1'b0;

    // Reset sweep with a write to r3 requested every cycle
    tick();
    tick();
    check("rst_busy", {31'd0, Busy}, 32'd1);
    check("rst_reject", {31'd0, Write_Reject}, 32'd0);
    check("rst_read_a", R_Data_A, 32'd0);
    Reset_n = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      tick();
      check($sformatf("sweep_busy_e%0d", e), {31'd0, Busy}, (e < 31) ? 32'd1 : 32'd0);
      check($sformatf("sweep_reject_e%0d", e), {31'd0, Write_Reject}, 32'd1);
    end
    tick();
    check("first_write_busy", {31'd0, Busy}, 32'd0);
    check("first_write_reject", {31'd0, Write_Reject}, 32'd0);
    check("first_write_r3", R_Data_A, 32'h1234_5678);
    Write_Reg = 1'b0;

    // Byte enables
    W_Addr = 5'd5; W_Data = 32'hFFFF_FFFF; W_Byte_En = 4'hF; Write_Reg = 1'b1;
    tick();
    W_Data = 32'h0000_AB00; W_Byte_En = 4'b0010;
    tick();
    Write_Reg = 1'b0; R_Addr_A = 5'd5;
    #1;
    check("byte_en_r5", R_Data_A, 32'hFFFF_ABFF);
    W_Data = 32'h0; W_Byte_En = 4'h0; Write_Reg = 1'b1;
    tick();
    Write_Reg = 1'b0;
    check("byte_en_none", R_Data_A, 32'hFFFF_ABFF);
    check("byte_en_none_reject", {31'd0, Write_Reject}, 32'd0);

    // Register 0
    W_Addr = 5'd0; W_Data = 32'hDEAD_BEEF; W_Byte_En = 4'hF; Write_Reg = 1'b1;
    R_Addr_A = 5'd0; R_Addr_B = 5'd0;
    tick();
    Write_Reg = 1'b0;
    #1;
    check("r0_read_a", R_Data_A, 32'd0);
    check("r0_read_b", R_Data_B, 32'd0);
    check("r0_reject", {31'd0, Write_Reject}, 32'd0);
    R_Addr_B = 5'd3;
    #1;
    check("r3_read_b", R_Data_B, 32'h1234_5678);

    // Forwarding, full word and partial merge
    R_Addr_B = 5'd9; W_Addr = 5'd9; W_Data = 32'hCAFE_0001; W_Byte_En = 4'hF; Write_Reg = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    fwd_exp = 32'hCAFE_0001;
`else
    fwd_exp = 32'h0;
`endif
    check("fwd_same_cycle", R_Data_B, fwd_exp);
    tick();
    Write_Reg = 1'b0;
    check("fwd_after_edge", R_Data_B, 32'hCAFE_0001);
    R_Addr_A = 5'd5; W_Addr = 5'd5; W_Data = 32'h1122_3344; W_Byte_En = 4'b0101; Write_Reg = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    fwd_exp = 32'hFF22_AB44;
`else
    fwd_exp = 32'hFFFF_ABFF;
`endif
    check("fwd_merge", R_Data_A, fwd_exp);
    tick();
    Write_Reg = 1'b0;
    check("merge_stored", R_Data_A, 32'hFF22_AB44);

    // Clear versus write on r7; a second Clr_Req mid-sweep must be ignored
    W_Addr = 5'd7; W_Data = 32'h55; W_Byte_En = 4'hF; Write_Reg = 1'b1;
    tick();
    Clr_Req = 1'b1; W_Data = 32'h99;
    tick();
    Clr_Req = 1'b0; Write_Reg = 1'b0;
    check("clr_reject", {31'd0, Write_Reject}, 32'd1);
    check("clr_busy_e1", {31'd0, Busy}, 32'd1);
    for (int e = 2; e <= 32; e++) begin
      Clr_Req = (e == 10);
      tick();
      check($sformatf("clr_busy_e%0d", e), {31'd0, Busy}, (e < 32) ? 32'd1 : 32'd0);
    end
    Clr_Req = 1'b0;
    check("clr_reject_low", {31'd0, Write_Reject}, 32'd0);
    R_Addr_A = 5'd7; R_Addr_B = 5'd3;
    #1;
    check("clr_r7", R_Data_A, 32'd0);
    check("clr_r3", R_Data_B, 32'd0);

    // Reset mid-sweep restarts from entry 1
    Clr_Req = 1'b1;
    tick();
    Clr_Req = 1'b0;
    for (int e = 0; e < 9; e++) tick();
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, Busy}, 32'd1);
    tick();
    Reset_n = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      tick();
      check($sformatf("midrst_busy_e%0d", e), {31'd0, Busy}, (e < 31) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
